// File: rtl/common.sv
// Package common: shared ALU command encoding and widths.
//   alu_op_t    - 3-bit ALU command codes (ALU_*), passed through unchanged
//   ALU_CMD_W   - width of an ALU command
//   ALU_DATA_W  - width of ALU operands and result
//   arb_state_t - alu_arbiter FSM state (IDLE = no response outstanding)
package common;

  localparam int ALU_CMD_W  = 3;
  localparam int ALU_DATA_W = 32;

  typedef enum logic [ALU_CMD_W-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority picker.
//   req   [N-1:0]  - request vector
//   ptr   [PW-1:0] - index that has highest priority this cycle
//   grant [N-1:0]  - one-hot grant (zero when no request)
// With ptr tied to 0 it is a plain lowest-index-wins priority picker.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  always_comb begin
    logic found;
    int   j;
    grant = '0;
    found = 1'b0;
    j     = 0;
    // Scan N positions starting at ptr, wrapping past N-1 back to 0.
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        grant[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered execute-stage ALU between NUM_REQ
// requesters. At most one request is granted per cycle; the ALU result
// appears one cycle later and is returned to the granted requester.
//
// Configuration macro: ALU_ARB_RR_EN
//   defined   - round-robin grant starting at rr_ptr
//   undefined - fixed priority, lowest index wins (no rr_ptr register)
//
// Ports:
//   clk, reset_n             - clock, synchronous active-low reset
//   req_valid / req_ready    - per-requester request handshake
//   req_cmd / req_a / req_b  - packed per-requester command and operands
//   resp_valid / resp_ready  - per-requester response handshake
//   resp_data                - result for the requester owning the response
//   alu_valid, alu_command,
//   alu_in_a, alu_in_b       - drive the ALU
//   alu_result               - ALU registered result (held while valid=0)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold valid and payload stable until ready; the
// response stays valid with a stable result until resp_ready is seen.
module alu_arbiter
  import common::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = ALU_DATA_W
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [ALU_CMD_W*NUM_REQ-1:0]   req_cmd,
  input  logic [DATA_W*NUM_REQ-1:0]      req_a,
  input  logic [DATA_W*NUM_REQ-1:0]      req_b,
  output logic [NUM_REQ-1:0]             resp_valid,
  input  logic [NUM_REQ-1:0]             resp_ready,
  output logic [DATA_W-1:0]              resp_data,
  output logic                           alu_valid,
  output logic [ALU_CMD_W-1:0]           alu_command,
  output logic [DATA_W-1:0]              alu_in_a,
  output logic [DATA_W-1:0]              alu_in_b,
  input  logic [DATA_W-1:0]              alu_result
);

  localparam int PW = $clog2(NUM_REQ);

  arb_state_t    state, state_next;
  logic [PW-1:0] owner, owner_next;
  logic [PW-1:0] ptr;
  logic          pending;
  logic          issue_ok;
  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0] grant_idx;
  logic          any_grant;

  assign pending = (state == ARB_BUSY);

  // A new op may issue when nothing is outstanding or the outstanding
  // response is accepted this cycle (the ALU register is then free).
  assign issue_ok   = reset_n && (!pending || resp_ready[owner]);
  assign req_masked = issue_ok ? req_valid : '0;

`ifdef ALU_ARB_RR_EN
  logic [PW-1:0] rr_ptr, rr_ptr_next;
  assign ptr = rr_ptr;
`else
  assign ptr = '0;
`endif

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr_arbiter (
    .req   (req_masked),
    .ptr   (ptr),
    .grant (grant)
  );

  assign req_ready = grant;
  assign any_grant = |grant;

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = PW'(i);
    end
  end

  // ALU drive: granted requester's fields, zero when idle.
  always_comb begin
    alu_valid   = 1'b0;
    alu_command = '0;
    alu_in_a    = '0;
    alu_in_b    = '0;
    if (any_grant) begin
      alu_valid   = 1'b1;
      alu_command = req_cmd[ALU_CMD_W*int'(grant_idx) +: ALU_CMD_W];
      alu_in_a    = req_a[DATA_W*int'(grant_idx) +: DATA_W];
      alu_in_b    = req_b[DATA_W*int'(grant_idx) +: DATA_W];
    end
  end

  // Response side depends only on state, so resp_ready never reaches it.
  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      resp_valid[i] = pending && (owner == PW'(i));
    end
    resp_data = pending ? alu_result : '0;
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
`ifdef ALU_ARB_RR_EN
    rr_ptr_next = rr_ptr;
`endif
    if (any_grant) begin
      state_next = ARB_BUSY;
      owner_next = grant_idx;
`ifdef ALU_ARB_RR_EN
      rr_ptr_next = (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + PW'(1);
`endif
    end else if (pending && resp_ready[owner]) begin
      state_next = ARB_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
      owner <= '0;
`ifdef ALU_ARB_RR_EN
      rr_ptr <= '0;
`endif
    end else begin
      state <= state_next;
      owner <= owner_next;
`ifdef ALU_ARB_RR_EN
      rr_ptr <= rr_ptr_next;
`endif
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with two requesters
// and a behavioural registered ALU. Table-driven single ops, then
// hand-written round-robin, back-pressure and reset sequences; a monitor
// scoreboards every granted op against its delivered response.
module tb_alu_arbiter;
  import common::*;

  localparam int N = 2;
  localparam int W = 32;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [3*N-1:0] req_cmd;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready;
  logic [W-1:0]   resp_data;
  logic           alu_valid;
  logic [2:0]     alu_command;
  logic [W-1:0]   alu_in_a;
  logic [W-1:0]   alu_in_b;
  logic [W-1:0]   alu_result;

  int n_total = 0;
  int n_pass  = 0;
  logic [W-1:0] exp_q[$];

  alu_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cmd     (req_cmd),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .alu_valid   (alu_valid),
    .alu_command (alu_command),
    .alu_in_a    (alu_in_a),
    .alu_in_b    (alu_in_b),
    .alu_result  (alu_result)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_model(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (alu_op_t'(op))
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLT: return {31'd0, $signed(a) < $signed(b)};
      ALU_SLL: return a << b[4:0];
      default: return a >> b[4:0];
    endcase
  endfunction

  // Behavioural registered ALU: updates on valid, holds otherwise.
  always @(posedge clk) begin
    if (!reset_n) alu_result <= '0;
    else if (alu_valid) alu_result <= alu_model(alu_command, alu_in_a, alu_in_b);
  end

  // ---------------- check helper ----------------
  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(int r, logic [2:0] cmd, logic [W-1:0] a, logic [W-1:0] b);
    req_cmd[3*r +: 3] = cmd;
    req_a[W*r +: W]   = a;
    req_b[W*r +: W]   = b;
  endtask

  task automatic pulse_reset(int cycles);
    reset_n = 1'b0;
    for (int c = 0; c < cycles; c++) next_cycle();
    exp_q.delete();
    reset_n = 1'b1;
  endtask

  // ---------------- scoreboard monitor ----------------
  // Sampled mid-cycle: a response fire pops the oldest expectation, a grant
  // pushes the model result computed from the requester's own fields.
  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < N; i++) begin
        if (resp_valid[i] === 1'b1 && resp_ready[i] === 1'b1) begin
          if (exp_q.size() == 0) check("sb_underflow", resp_data, 32'hDEAD_BEEF);
          else check("sb_resp", resp_data, exp_q.pop_front());
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] === 1'b1)
          exp_q.push_back(alu_model(req_cmd[3*i +: 3], req_a[W*i +: W], req_b[W*i +: W]));
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int         r;
    logic [2:0] cmd;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [N-1:0] oh;
    logic [N-1:0] exp_g;
    logic [W-1:0] prev_res;

    vecs[0] = '{0, ALU_ADD, 32'd5,        32'd7,        32'd12};
    vecs[1] = '{0, ALU_SUB, 32'd10,       32'd3,        32'd7};
    vecs[2] = '{1, ALU_OR,  32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF};
    vecs[3] = '{1, ALU_AND, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_0F00};
    vecs[4] = '{0, ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
    vecs[5] = '{1, ALU_SLT, 32'hFFFF_FFFF, 32'd1,        32'd1};
    vecs[6] = '{0, ALU_SLL, 32'd1,        32'd31,       32'h8000_0000};
    vecs[7] = '{1, ALU_SRL, 32'h8000_0000, 32'd4,        32'h0800_0000};

    reset_n    = 1'b0;
    req_valid  = '0;
    req_cmd    = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '0;

    // Reset held 3 cycles with every requester valid.
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_alu_valid", 32'(alu_valid), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
    end
    req_valid = '0;
    exp_q.delete();
    reset_n = 1'b1;
    next_cycle();
    @(negedge clk);
    check("post_rst_resp_data", resp_data, 32'd0);
    check("post_rst_alu_cmd", 32'(alu_command), 32'd0);
    check("post_rst_alu_a", alu_in_a, 32'd0);
    check("post_rst_alu_b", alu_in_b, 32'd0);
    next_cycle();

    // Table: single ops, resp_ready held high.
    resp_ready = '1;
    for (int v = 0; v < 8; v++) begin
      oh = N'(1) << vecs[v].r;
      drive_req(vecs[v].r, vecs[v].cmd, vecs[v].a, vecs[v].b);
      req_valid = oh;
      @(negedge clk);
      check("vec_req_ready", 32'(req_ready), 32'(oh));
      check("vec_alu_valid", 32'(alu_valid), 32'd1);
      check("vec_alu_cmd", 32'(alu_command), 32'(vecs[v].cmd));
      check("vec_alu_a", alu_in_a, vecs[v].a);
      check("vec_alu_b", alu_in_b, vecs[v].b);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      check("vec_resp_valid", 32'(resp_valid), 32'(oh));
      check("vec_resp_data", resp_data, vecs[v].exp);
      next_cycle();
    end

    // Both requesters valid continuously.
    pulse_reset(1);
    drive_req(0, ALU_SUB, 32'd10, 32'd3);
    drive_req(1, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
    req_valid  = 2'b11;
    resp_ready = 2'b11;
    prev_res   = '0;
    for (int k = 0; k < 6; k++) begin
`ifdef ALU_ARB_RR_EN
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b01;
`endif
      @(negedge clk);
      check("arb_grant", 32'(req_ready), 32'(exp_g));
      if (k > 0) check("arb_resp_data", resp_data, prev_res);
      prev_res = exp_g[0] ? 32'd7 : 32'h0000_00FF;
      next_cycle();
    end
    req_valid = '0;
    @(negedge clk);
    check("arb_last_resp", resp_data, prev_res);
    next_cycle();
    next_cycle();

    // Back-pressure on requester 1 while requester 0 waits.
    drive_req(1, ALU_AND, 32'h0000_FF00, 32'h0000_0FF0);
    req_valid = 2'b10;
    @(negedge clk);
    check("bp_grant1", 32'(req_ready), 32'b10);
    next_cycle();
    drive_req(0, ALU_ADD, 32'd1, 32'd2);
    req_valid  = 2'b01;
    resp_ready = 2'b01;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_resp_valid", 32'(resp_valid), 32'b10);
      check("bp_resp_hold", resp_data, 32'h0000_0F00);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_alu_valid", 32'(alu_valid), 32'd0);
      next_cycle();
    end
    resp_ready = 2'b11;
    @(negedge clk);
    check("bp_release_grant", 32'(req_ready), 32'b01);
    check("bp_release_resp", resp_data, 32'h0000_0F00);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("bp_next_resp_valid", 32'(resp_valid), 32'b01);
    check("bp_next_resp_data", resp_data, 32'd3);
    next_cycle();
    next_cycle();

    // Reset while a response is outstanding.
    drive_req(0, ALU_XOR, 32'h1234_5678, 32'hFFFF_FFFF);
    req_valid = 2'b01;
    @(negedge clk);
    check("rmid_grant", 32'(req_ready), 32'b01);
    next_cycle();
    req_valid  = 2'b11;
    resp_ready = '0;
    reset_n    = 1'b0;
    @(negedge clk);
    check("rmid_pending", 32'(resp_valid), 32'b01);
    check("rmid_no_issue", 32'(req_ready), 32'd0);
    exp_q.delete();
    next_cycle();
    @(negedge clk);
    check("rmid_dropped", 32'(resp_valid), 32'd0);
    check("rmid_data_zero", resp_data, 32'd0);
    check("rmid_req_ready", 32'(req_ready), 32'd0);
    check("rmid_alu_valid", 32'(alu_valid), 32'd0);
    req_valid  = '0;
    resp_ready = '1;
    reset_n    = 1'b1;
    next_cycle();
    @(negedge clk);
    check("rmid_idle_after", 32'(resp_valid), 32'd0);
    next_cycle();

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
